// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for an up/down load/clear counter: loads Lo, counts to Hi and
// back to Lo, Reps times, then pulses Done. Supports pause, abort and range supervision.
module count_sweep_ctrl #(
  parameter int WIDTH = 16,
  parameter int REPW  = 8
) (
  input  logic             Clock,
  input  logic             Aclr,
  input  logic             Start,
  input  logic             Pause,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Lo,
  input  logic [WIDTH-1:0] Hi,
  input  logic [REPW-1:0]  Reps,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Data,
  output logic             Sload,
  output logic             Sclr,
  output logic             Cnt_En,
  output logic             UpDown,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [REPW-1:0]  Pass_Cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [REPW-1:0]  reps_q, reps_d, pass_q, pass_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [REPW:0]    pass_next;
  logic             more_passes, out_of_range;

  always_comb begin
    // One extra bit so Reps = 2^REPW-1 compares exactly without wrapping.
    pass_next    = {1'b0, pass_q} + {{REPW{1'b0}}, 1'b1};
    more_passes  = (pass_next < {1'b0, reps_q});
    out_of_range = (Q < lo_q) || (Q > hi_q);

    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    reps_d  = reps_q;
    pass_d  = pass_q;
    err_d   = err_q;
    Data    = lo_q;
    Sload   = 1'b0;
    Sclr    = 1'b0;
    Cnt_En  = 1'b0;
    UpDown  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if ((Lo < Hi) && (Reps != '0)) begin
            lo_d    = Lo;
            hi_d    = Hi;
            reps_d  = Reps;
            pass_d  = '0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        Sload   = 1'b1;
        state_d = S_UP;
      end
      S_UP: begin
        if (out_of_range) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!Pause) begin
          Cnt_En = 1'b1;
          if (Q == hi_q) state_d = S_DOWN;
          else           UpDown  = 1'b1;
        end
      end
      S_DOWN: begin
        if (out_of_range) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!Pause) begin
          if (Q != lo_q) begin
            Cnt_En = 1'b1;
          end else if (more_passes) begin
            Cnt_En  = 1'b1;
            UpDown  = 1'b1;
            pass_d  = pass_next[REPW-1:0];
            state_d = S_UP;
          end else begin
            pass_d  = pass_next[REPW-1:0];
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything decoded above, including a same-cycle Start.
    if (Abort) begin
      Sclr    = 1'b1;
      Sload   = 1'b0;
      Cnt_En  = 1'b0;
      UpDown  = 1'b0;
      lo_d    = lo_q;
      hi_d    = hi_q;
      reps_d  = reps_q;
      err_d   = err_q;
      pass_d  = '0;
      state_d = S_IDLE;
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_DOWN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign Pass_Cnt  = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: an LPM-style counter model closes the loop, and a
// sweep-trajectory model predicts every cycle's outputs and counter value.
module tb_count_sweep_ctrl;
  localparam int W  = 16;
  localparam int RW = 8;

  logic          Clock = 1'b0;
  logic          Aclr  = 1'b1;
  logic          Start = 1'b0;
  logic          Pause = 1'b0;
  logic          Abort = 1'b0;
  logic [W-1:0]  Lo    = '0;
  logic [W-1:0]  Hi    = '0;
  logic [RW-1:0] Reps  = '0;
  logic [W-1:0]  Q     = '0;
  logic [W-1:0]  Data;
  logic          Sload, Sclr, Cnt_En, UpDown, Busy, Done, Err;
  logic [RW-1:0] Pass_Cnt;
  logic [2:0]    dbg_state;

  int            n_checks = 0;
  int            n_errors = 0;
  logic          force_req = 1'b0;
  logic [W-1:0]  force_val = '0;

  count_sweep_ctrl #(.WIDTH(W), .REPW(RW)) dut (
    .Clock(Clock), .Aclr(Aclr), .Start(Start), .Pause(Pause), .Abort(Abort),
    .Lo(Lo), .Hi(Hi), .Reps(Reps), .Q(Q), .Data(Data), .Sload(Sload),
    .Sclr(Sclr), .Cnt_En(Cnt_En), .UpDown(UpDown), .Busy(Busy), .Done(Done),
    .Err(Err), .Pass_Cnt(Pass_Cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // Counter datapath: sclr > sload > count; force_req models an external disturbance.
  always @(posedge Clock) begin
    if (force_req)   Q <= force_val;
    else if (Sclr)   Q <= '0;
    else if (Sload)  Q <= Data;
    else if (Cnt_En) Q <= UpDown ? Q + 16'd1 : Q - 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is the list of counter values it must visit, one per non-paused cycle.
  typedef struct {
    logic [W-1:0]  q;
    logic [RW-1:0] pass;
    bit            done;
  } step_t;

  step_t         exp_q[$];
  logic [W-1:0]  m_q = '0, m_lo = '0, m_hi = '0;
  logic [RW-1:0] m_pass = '0;
  bit            m_busy = 0, m_done = 0, m_err = 0, m_load = 0;

  task automatic build_run(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [RW-1:0] reps);
    exp_q.delete();
    exp_q.push_back('{q: lo, pass: '0, done: 1'b0});
    for (int p = 0; p < int'(reps); p++) begin
      for (int v = int'(lo) + 1; v <= int'(hi); v++)
        exp_q.push_back('{q: W'(v), pass: RW'(p), done: 1'b0});
      for (int v = int'(hi) - 1; v >= int'(lo); v--)
        exp_q.push_back('{q: W'(v), pass: RW'(p), done: 1'b0});
    end
    exp_q.push_back('{q: lo, pass: reps, done: 1'b1});
  endtask

  always @(negedge Clock) begin
    step_t s;
    bit e_sload, e_sclr, e_cnt, e_ud;
    e_sload = 0; e_sclr = 0; e_cnt = 0; e_ud = 0;
    check("q", Q, m_q);
    if (Aclr) begin
      exp_q.delete();
      m_pass = '0; m_busy = 0; m_done = 0; m_err = 0; m_load = 0; m_lo = '0; m_hi = '0;
      e_sclr = Abort;
    end
    check("busy", Busy, m_busy);
    check("done", Done, m_done);
    check("err", Err, m_err);
    check("pass", Pass_Cnt, m_pass);
    check("data", Data, m_lo);
    if (!Aclr) begin
      if (Abort) begin
        e_sclr = 1;
        exp_q.delete();
        m_pass = '0; m_busy = 0; m_done = 0; m_load = 0; m_q = '0;
      end else if (exp_q.size() != 0) begin
        if (!m_load && (m_q < m_lo || m_q > m_hi)) begin
          m_err = 1; m_busy = 0;
          exp_q.delete();
        end else if (!(Pause && !m_load)) begin
          s = exp_q.pop_front();
          if (m_load) e_sload = 1;
          else if (!s.done) begin
            e_cnt = 1;
            e_ud  = (s.q > m_q);
          end
          m_q = s.q; m_pass = s.pass; m_busy = !s.done; m_done = s.done; m_load = 0;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (Start) begin
        if (Lo < Hi && Reps != '0) begin
          build_run(Lo, Hi, Reps);
          m_lo = Lo; m_hi = Hi; m_err = 0; m_pass = '0; m_busy = 1; m_load = 1;
        end else begin
          m_err = 1;
        end
      end
      if (force_req) m_q = force_val;
    end
    check("sload", Sload, e_sload);
    check("sclr", Sclr, e_sclr);
    check("cnt_en", Cnt_En, e_cnt);
    check("updown", UpDown, e_ud);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [RW-1:0] reps);
    Lo = lo; Hi = hi; Reps = reps; Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic wait_qp(input logic [W-1:0] v, input logic [RW-1:0] p, input string name);
    int k = 0;
    while (!(Q == v && Pass_Cnt == p && Busy) && k < 300) begin
      cyc();
      k++;
    end
    check(name, (Q == v && Pass_Cnt == p && Busy), 1);
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    while (!Done && k < bound) begin
      cyc();
      k++;
    end
    check(name, Done, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] exp1 [0:8];
  int           k;

  initial begin
    exp1 = '{16'd3, 16'd4, 16'd5, 16'd4, 16'd3, 16'd4, 16'd5, 16'd4, 16'd3};
    repeat (3) @(posedge Clock);
    #1 Aclr = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Err, 0);
    check("rst_pass", Pass_Cnt, 0);
    check("rst_data", Data, 0);
    check("rst_cnt_en", Cnt_En, 0);
    cyc();

    // Basic two-pass sweep with literal counter trajectory.
    start_run(16'd3, 16'd5, 8'd2);
    check("s1_sload", Sload, 1);
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("s1_q_traj", Q, exp1[i]);
    end
    cyc();
    check("s1_done", Done, 1);
    check("s1_pass", Pass_Cnt, 2);
    check("s1_busy", Busy, 0);
    cyc();
    check("s1_done_pulse", Done, 0);

    // Rejected starts.
    start_run(16'd5, 16'd5, 8'd1);
    check("bad_eq_err", Err, 1);
    check("bad_eq_busy", Busy, 0);
    start_run(16'd7, 16'd2, 8'd1);
    check("bad_inv_err", Err, 1);
    check("bad_inv_busy", Busy, 0);
    start_run(16'd3, 16'd5, 8'd0);
    check("bad_reps_err", Err, 1);
    check("bad_reps_busy", Busy, 0);

    // Pause for four cycles at Q=2 on the way up.
    start_run(16'd0, 16'd3, 8'd1);
    check("p_err_cleared", Err, 0);
    repeat (3) cyc();
    check("p_q_at_2", Q, 2);
    Pause = 1'b1;
    #1 check("p_cnt_en", Cnt_En, 0);
    repeat (4) begin
      cyc();
      check("p_hold", Q, 2);
    end
    Pause = 1'b0;
    k = 0;
    while (!Done && k < 20) begin
      cyc();
      k++;
    end
    check("p_done_edge", 7 + k, 12);
    check("p_pass", Pass_Cnt, 1);
    cyc();

    // Abort at Q=15 during the second pass.
    start_run(16'd10, 16'd20, 8'd3);
    wait_qp(16'd15, 8'd1, "ab_reach");
    Abort = 1'b1;
    #1 check("ab_sclr", Sclr, 1);
    check("ab_cnt_en", Cnt_En, 0);
    cyc();
    Abort = 1'b0;
    check("ab_q0", Q, 0);
    check("ab_busy", Busy, 0);
    check("ab_pass", Pass_Cnt, 0);
    repeat (4) begin
      cyc();
      check("ab_no_done", Done, 0);
    end

    // Counter disturbed out of range, then a clean rerun.
    start_run(16'd10, 16'd20, 8'd1);
    wait_qp(16'd13, 8'd0, "rg_reach");
    force_val = 16'd25;
    force_req = 1'b1;
    cyc();
    force_req = 1'b0;
    check("rg_forced", Q, 25);
    cyc();
    check("rg_err", Err, 1);
    check("rg_busy", Busy, 0);
    start_run(16'd10, 16'd20, 8'd1);
    check("rg_err_cleared", Err, 0);
    check("rg_busy_rerun", Busy, 1);
    wait_done(100, "rg_rerun_done");
    check("rg_rerun_pass", Pass_Cnt, 1);
    cyc();

    // Asynchronous clear while counting down.
    start_run(16'd0, 16'd4, 8'd1);
    repeat (6) cyc();
    check("ac_q_down", Q, 3);
    #2 Aclr = 1'b1;
    #1;
    check("ac_busy", Busy, 0);
    check("ac_cnt_en", Cnt_En, 0);
    check("ac_done", Done, 0);
    check("ac_err", Err, 0);
    check("ac_pass", Pass_Cnt, 0);
    repeat (2) cyc();
    Aclr = 1'b0;
    check("ac_q_kept", Q, 3);
    start_run(16'd0, 16'd4, 8'd1);
    check("ac_sload", Sload, 1);
    wait_done(100, "ac_rerun_done");
    check("ac_rerun_pass", Pass_Cnt, 1);
    cyc();

    // Maximum repetition count at the top of the range.
    start_run(16'hFFFE, 16'hFFFF, 8'd255);
    wait_done(600, "max_reps_done");
    check("max_reps_pass", Pass_Cnt, 255);
    cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] base;
      base  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h0000;
      Lo    = base + W'($urandom_range(0, 2));
      Hi    = Lo + W'($urandom_range(0, 5));
      Reps  = RW'($urandom_range(0, 3));
      Start = ($urandom_range(0, 5) == 0);
      Pause = ($urandom_range(0, 3) == 0);
      Abort = ($urandom_range(0, 63) == 0);
      cyc();
    end
    Start = 1'b0;
    Pause = 1'b0;
    Abort = 1'b0;
    repeat (80) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
